// File: rtl/egress_frame_reader_pkg.sv
// Shared types and constants for the egress frame reader: sideband descriptor
// layout, AXI-stream source/sink bundles and the reader state encoding.
package egress_frame_reader_pkg;

   localparam int MAX_FRAME_HWORDS = 759;
   localparam int SB_DROP_BIT      = 19;
   localparam int SB_LEN_LSB       = 0;
   localparam int SB_LEN_W         = 11;

   typedef struct packed {
      logic        drop;
      logic [7:0]  rsvd;
      logic [10:0] len;
   } sideband_t;

   typedef struct packed {
      logic [15:0] tdata;
      logic        tvalid;
      logic        tlast;
   } axis_source_t;

   typedef struct packed {
      logic tready;
   } axis_sink_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SB_WAIT = 2'd1,
      ST_STREAM  = 2'd2,
      ST_DROP    = 2'd3
   } state_t;

   function automatic sideband_t sb_unpack(input logic [19:0] word);
      sideband_t sb;
      sb.drop = word[SB_DROP_BIT];
      sb.rsvd = word[SB_DROP_BIT-1:SB_LEN_LSB+SB_LEN_W];
      sb.len  = word[SB_LEN_LSB +: SB_LEN_W];
      return sb;
   endfunction

endpackage

// File: rtl/egress_frame_reader_axis_skid_buf.sv
// Two-entry data+last buffer whose head entry drives an AXI-stream source.
// Head only changes on a handshake or when loaded from empty, so the stream stays stable under backpressure.
module egress_frame_reader_axis_skid_buf
   import egress_frame_reader_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [15:0]  data,
   input  logic         last,
   input  logic         tready,
   output logic [1:0]   count,
   output axis_source_t source
);

   logic [15:0] r_data0;
   logic [15:0] r_data1;
   logic        r_last0;
   logic        r_last1;
   logic [1:0]  r_count;
   logic        w_pop;

   assign w_pop = (r_count != 2'd0) && tready;

   // entry storage and occupancy; push and pop together leave the count unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data0 <= 16'd0;
         r_data1 <= 16'd0;
         r_last0 <= 1'b0;
         r_last1 <= 1'b0;
         r_count <= 2'd0;
      end else begin
         case ({push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_data0 <= data;
                  r_last0 <= last;
                  r_count <= 2'd1;
               end else if (r_count == 2'd1) begin
                  r_data1 <= data;
                  r_last1 <= last;
                  r_count <= 2'd2;
               end else begin
                  r_count <= r_count;
               end
            end
            2'b01: begin
               r_data0 <= r_data1;
               r_last0 <= r_last1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_data0 <= data;
                  r_last0 <= last;
               end else begin
                  r_data0 <= r_data1;
                  r_last0 <= r_last1;
                  r_data1 <= data;
                  r_last1 <= last;
               end
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

   assign count         = r_count;
   assign source.tvalid = (r_count != 2'd0);
   assign source.tdata  = r_data0;
   assign source.tlast  = r_last0;

endmodule

// File: rtl/egress_frame_reader.sv
// Pops a sideband descriptor per frame, then streams or discards that frame's
// half-words from the frame FIFO; legal frames go out as AXI-stream with tlast.
module egress_frame_reader
   import egress_frame_reader_pkg::*;
#(
   parameter int LEN_W   = SB_LEN_W,
   parameter int MAX_LEN = MAX_FRAME_HWORDS,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic             sb_ren,
   input  logic [19:0]      sb_rdata,
   input  logic             sb_empty,
   output logic             frame_ren,
   input  logic [19:0]      frame_rdata,
   input  logic             frame_empty,
   output axis_source_t     egress_source,
   input  axis_sink_t       egress_sink,
   output logic             len_err,
   output logic [CNT_W-1:0] frames_sent,
   output logic [CNT_W-1:0] frames_dropped
);

   state_t           r_state;
   state_t           w_next;
   logic [LEN_W-1:0] r_rem;
   logic [LEN_W-1:0] w_rem_cur;
   logic [LEN_W-1:0] w_rem_nxt;
   logic             r_inflight;
   logic             r_inflight_last;
   logic [CNT_W-1:0] r_sent;
   logic [CNT_W-1:0] r_dropped;
   logic             w_sent_inc;
   logic             w_drop_inc;
   logic [1:0]       w_count;
   logic             w_pop;
   logic             w_push;
   logic [2:0]       w_occ;
   sideband_t        w_sb;
   logic [LEN_W-1:0] w_len;
   logic             w_unused_bits;

   assign w_sb          = sb_unpack(sb_rdata);
   assign w_len         = LEN_W'(w_sb.len);
   assign w_unused_bits = ^{frame_rdata[19:16], w_sb.rsvd};

   assign w_pop  = egress_source.tvalid && egress_sink.tready;
   assign w_push = r_inflight && (r_state == ST_STREAM);
   // words held plus the one returning now, less the one leaving this cycle
   assign w_occ  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

   egress_frame_reader_axis_skid_buf u_skid (
      .clk    (clk),
      .reset  (reset),
      .push   (w_push),
      .data   (frame_rdata[15:0]),
      .last   (r_inflight_last),
      .tready (egress_sink.tready),
      .count  (w_count),
      .source (egress_source)
   );

   // next-state, FIFO strobes, error pulse and counter increments
   always_comb begin
      w_next     = r_state;
      sb_ren     = 1'b0;
      frame_ren  = 1'b0;
      len_err    = 1'b0;
      w_sent_inc = 1'b0;
      w_drop_inc = 1'b0;
      w_rem_cur  = r_rem;
      if (reset) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en && !sb_empty) begin
                  sb_ren = 1'b1;
                  w_next = ST_SB_WAIT;
               end else begin
                  w_next = ST_IDLE;
               end
            end
            ST_SB_WAIT: begin
               w_rem_cur = w_len;
               if (w_len == {LEN_W{1'b0}}) begin
                  len_err = 1'b1;
                  w_next  = ST_IDLE;
               end else if (w_len > LEN_W'(MAX_LEN)) begin
                  len_err = 1'b1;
                  w_next  = ST_DROP;
               end else if (w_sb.drop) begin
                  w_next = ST_DROP;
               end else begin
                  // first read issues here so the head word is valid two cycles later
                  frame_ren = !frame_empty;
                  w_next    = ST_STREAM;
               end
            end
            ST_STREAM: begin
               frame_ren = !frame_empty && (r_rem != {LEN_W{1'b0}}) && (w_occ < 3'd2);
               if (w_pop && egress_source.tlast) begin
                  w_sent_inc = 1'b1;
                  w_next     = ST_IDLE;
               end else begin
                  w_next = ST_STREAM;
               end
            end
            ST_DROP: begin
               frame_ren = !frame_empty && (r_rem != {LEN_W{1'b0}});
               if ((r_rem == {LEN_W{1'b0}}) && r_inflight) begin
                  w_drop_inc = 1'b1;
                  w_next     = ST_IDLE;
               end else begin
                  w_next = ST_DROP;
               end
            end
            default: begin
               w_next = ST_IDLE;
            end
         endcase
      end
      w_rem_nxt = frame_ren ? (w_rem_cur - {{(LEN_W-1){1'b0}}, 1'b1}) : w_rem_cur;
   end

   // state, remaining-word count, in-flight read tracking and frame counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_rem           <= {LEN_W{1'b0}};
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_sent          <= {CNT_W{1'b0}};
         r_dropped       <= {CNT_W{1'b0}};
      end else begin
         r_state         <= w_next;
         r_rem           <= w_rem_nxt;
         r_inflight      <= frame_ren;
         r_inflight_last <= frame_ren && (w_rem_cur == {{(LEN_W-1){1'b0}}, 1'b1});
         if (w_sent_inc) begin
            r_sent <= r_sent + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (w_drop_inc) begin
            r_dropped <= r_dropped + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign frames_sent    = r_sent;
   assign frames_dropped = r_dropped;

endmodule

// File: tb/tb_egress_frame_reader.sv
// Self-checking bench: FIFO models feed the reader, a frame-level reference
// model fills a scoreboard, and a negedge monitor checks every beat.
module tb_egress_frame_reader;
   import egress_frame_reader_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic         sb_ren;
   logic [19:0]  sb_rdata;
   logic         sb_empty;
   logic         frame_ren;
   logic [19:0]  frame_rdata;
   logic         frame_empty;
   axis_source_t egress_source;
   axis_sink_t   egress_sink;
   logic         len_err;
   logic [15:0]  frames_sent;
   logic [15:0]  frames_dropped;
   logic         tready_drv;

   assign egress_sink.tready = tready_drv;

   egress_frame_reader dut (
      .clk            (clk),
      .reset          (reset),
      .en             (en),
      .sb_ren         (sb_ren),
      .sb_rdata       (sb_rdata),
      .sb_empty       (sb_empty),
      .frame_ren      (frame_ren),
      .frame_rdata    (frame_rdata),
      .frame_empty    (frame_empty),
      .egress_source  (egress_source),
      .egress_sink    (egress_sink),
      .len_err        (len_err),
      .frames_sent    (frames_sent),
      .frames_dropped (frames_dropped)
   );

   always #5 clk = ~clk;

   logic [19:0] sbq[$];
   logic [15:0] fq[$];
   bit          ftx[$];
   logic [16:0] expq[$];

   int checks = 0;
   int errors = 0;
   int exp_sent = 0, exp_dropped = 0, exp_lenerr = 0, obs_lenerr = 0;
   int outstanding = 0, cyc = 0, hs_count = 0, fr_count = 0;
   int first_sbren = -1, first_tvalid = -1, last_hs = -1;
   int tr_mode = 0;
   bit rnd_empty = 1'b0;
   bit hold_empty = 1'b0;
   bit rnd_hold = 1'b0;
   logic [6:0] tr_pat = 7'b1101001;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // reference model: one descriptor plus its words, outcome decided by frame rules
   task automatic add_frame(input bit drop, input int len, input bit pat);
      logic [19:0] d;
      logic [15:0] w;
      logic [7:0]  rs;
      bit          tx;
      rs = 8'($urandom);
      d  = {drop, rs, 11'(len)};
      sbq.push_back(d);
      tx = !drop && (len <= 759);
      if (len == 0) begin
         exp_lenerr++;
      end else begin
         if (len > 759) exp_lenerr++;
         if (tx) exp_sent++;
         else exp_dropped++;
         for (int i = 0; i < len; i++) begin
            w = pat ? 16'((i + 1) * 16'h1111) : 16'($urandom);
            fq.push_back(w);
            ftx.push_back(tx);
            if (tx) expq.push_back({(i == len - 1), w});
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while ((sbq.size() != 0 || fq.size() != 0 || expq.size() != 0 || outstanding != 0) && n < 6000) begin
         tick();
         n++;
      end
      chk({nm, "_drained"}, 32'(n < 6000), 32'd1);
      repeat (4) tick();
      chk({nm, "_frames_sent"}, 32'(frames_sent), 32'(exp_sent & 16'hffff));
      chk({nm, "_frames_dropped"}, 32'(frames_dropped), 32'(exp_dropped & 16'hffff));
      chk({nm, "_len_err_pulses"}, 32'(obs_lenerr), 32'(exp_lenerr));
   endtask

   // tready pattern and random frame-FIFO starvation
   initial begin
      int idx;
      idx = 0;
      tready_drv = 1'b1;
      forever begin
         tick();
         case (tr_mode)
            0: begin tready_drv = 1'b1; idx = 0; end
            1: begin
               tready_drv = (idx < 7) ? tr_pat[idx] : 1'b1;
               idx++;
            end
            default: begin tready_drv = 1'($urandom_range(0, 1)); idx = 0; end
         endcase
         rnd_hold = rnd_empty && ($urandom_range(0, 3) == 0);
      end
   end

   // FIFO models: read data appears the cycle after the strobe
   initial begin
      bit p_sb, p_fr;
      sb_empty    = 1'b1;
      frame_empty = 1'b1;
      sb_rdata    = 20'd0;
      frame_rdata = 20'd0;
      forever begin
         @(negedge clk);
         p_sb = sb_ren;
         p_fr = frame_ren;
         @(posedge clk);
         #1;
         if (p_sb && sbq.size() > 0) sb_rdata = sbq.pop_front();
         if (p_fr && fq.size() > 0) begin
            frame_rdata = {4'($urandom), fq.pop_front()};
            void'(ftx.pop_front());
         end
         #1;
         sb_empty    = (sbq.size() == 0);
         frame_empty = (fq.size() == 0) || hold_empty || rnd_hold;
      end
   end

   // monitor and scoreboard
   initial begin
      bit          prev_stall;
      logic [16:0] prev_word;
      prev_stall = 1'b0;
      prev_word  = 17'd0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               chk("axis_hold", {14'd0, egress_source.tvalid, egress_source.tlast, egress_source.tdata},
                   {15'd0, 1'b1, prev_word});
            chk("sb_ren_needs_en", 32'(sb_ren & ~en), 32'd0);
            if (sb_ren && first_sbren < 0) first_sbren = cyc;
            if (egress_source.tvalid && first_tvalid < 0) first_tvalid = cyc;
            if (len_err) obs_lenerr++;
            if (frame_ren) begin
               fr_count++;
               chk("read_when_empty", 32'(frame_empty), 32'd0);
               if (ftx.size() > 0 && ftx[0]) outstanding++;
            end
            if (egress_source.tvalid && tready_drv) begin
               hs_count++;
               last_hs = cyc;
               outstanding--;
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got data 0x%0h last %0b, no beat expected",
                           egress_source.tdata, egress_source.tlast);
               end else begin
                  chk("beat", {15'd0, egress_source.tlast, egress_source.tdata}, {15'd0, expq.pop_front()});
               end
            end
            if (frame_ren || (egress_source.tvalid && tready_drv))
               chk("buffer_bound", 32'(outstanding > 2), 32'd0);
            prev_stall = egress_source.tvalid && !tready_drv;
            prev_word  = {egress_source.tlast, egress_source.tdata};
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n;
      reset = 1'b1;
      en    = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_tvalid", 32'(egress_source.tvalid), 32'd0);
      chk("rst_sb_ren", 32'(sb_ren), 32'd0);
      chk("rst_frame_ren", 32'(frame_ren), 32'd0);
      chk("rst_len_err", 32'(len_err), 32'd0);
      chk("rst_frames_sent", 32'(frames_sent), 32'd0);
      chk("rst_frames_dropped", 32'(frames_dropped), 32'd0);

      // single legal frame, latency and full rate
      tick();
      first_sbren = -1; first_tvalid = -1;
      add_frame(1'b0, 4, 1'b1);
      en = 1'b1;
      wait_idle("single");
      chk("first_tvalid_latency", 32'(first_tvalid - first_sbren), 32'd3);
      chk("four_beats_back_to_back", 32'(last_hs - first_tvalid), 32'd3);

      // backpressure pattern
      base = hs_count;
      tr_mode = 1;
      add_frame(1'b0, 3, 1'b0);
      wait_idle("backpressure");
      chk("backpressure_beats", 32'(hs_count - base), 32'd3);
      tr_mode = 0;

      // dropped frame followed by a legal one
      base = fr_count;
      add_frame(1'b1, 5, 1'b0);
      add_frame(1'b0, 2, 1'b0);
      wait_idle("drop");
      chk("drop_reads", 32'(fr_count - base), 32'd7);

      // zero and oversize lengths
      base = fr_count;
      add_frame(1'b0, 0, 1'b0);
      add_frame(1'b0, 800, 1'b0);
      add_frame(1'b0, 2, 1'b0);
      wait_idle("len_err");
      chk("len_err_reads", 32'(fr_count - base), 32'd802);

      // starvation mid-frame with en dropped
      base = hs_count;
      add_frame(1'b0, 8, 1'b0);
      add_frame(1'b0, 3, 1'b0);
      n = 0;
      while (hs_count - base < 3 && n < 200) begin tick(); n++; end
      chk("underflow_reach_beat3", 32'(n < 200), 32'd1);
      hold_empty = 1'b1;
      en = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      chk("underflow_tvalid_low", 32'(egress_source.tvalid), 32'd0);
      tick();
      hold_empty = 1'b0;
      repeat (40) tick();
      chk("en_low_frame_done", 32'(frames_sent), 32'((exp_sent - 1) & 16'hffff));
      chk("en_low_no_pop", 32'(sbq.size()), 32'd1);
      en = 1'b1;
      wait_idle("underflow");

      // randomized traffic
      tr_mode = 2;
      rnd_empty = 1'b1;
      for (int f = 0; f < 25; f++) begin
         int r, len;
         r = $urandom_range(0, 9);
         if (r == 0) len = 0;
         else if (r == 1) len = $urandom_range(760, 780);
         else len = $urandom_range(1, 16);
         add_frame(($urandom_range(0, 3) == 0), len, 1'b0);
      end
      wait_idle("random");
      rnd_empty = 1'b0;
      tr_mode = 0;

      // reset in the middle of a frame
      base = hs_count;
      add_frame(1'b0, 6, 1'b0);
      n = 0;
      while (hs_count - base < 2 && n < 200) begin tick(); n++; end
      chk("midrst_reach_beat2", 32'(n < 200), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #2;
      sbq.delete(); fq.delete(); ftx.delete(); expq.delete();
      outstanding = 0; exp_sent = 0; exp_dropped = 0; exp_lenerr = 0; obs_lenerr = 0;
      @(negedge clk);
      chk("midrst_tvalid", 32'(egress_source.tvalid), 32'd0);
      chk("midrst_frames_sent", 32'(frames_sent), 32'd0);
      chk("midrst_frames_dropped", 32'(frames_dropped), 32'd0);
      tick();
      reset = 1'b0;
      add_frame(1'b0, 3, 1'b0);
      wait_idle("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/egress_frame_reader.md
Name: egress_frame_reader

Overview:
- Read-side counterpart of the ingress frame buffer.
- Pops one sideband descriptor per frame, then reads that frame's 16-bit half-words from the frame FIFO and transmits them as an AXI-stream with tlast on the final word.
- Frames flagged for drop, or with an oversize length, are read out and discarded without being transmitted.
- Sits between the shared frame/sideband FIFOs and the egress switch port.

Parameters:
- LEN_W, 11, width of the descriptor length field in half-words.
- MAX_LEN, 759, largest legal frame in half-words (1518 B).
- CNT_W, 16, width of the sent and dropped frame counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  allow new frames to start; sampled only in IDLE
- sb_ren  out  1  sideband FIFO read strobe
- sb_rdata  in  20  sideband word, valid 1 cycle after sb_ren; [19]=drop, [18:11]=reserved, [10:0]=length in half-words
- sb_empty  in  1  sideband FIFO empty
- frame_ren  out  1  frame FIFO read strobe
- frame_rdata  in  20  frame word, valid 1 cycle after frame_ren; [15:0]=data, [19:16]=ignored
- frame_empty  in  1  frame FIFO empty
- egress_source  out  axis_source_t  fields tdata[15:0], tvalid, tlast
- egress_sink  in  axis_sink_t  field tready
- len_err  out  1  one-cycle pulse when a descriptor has an illegal length
- frames_sent  out  CNT_W  count of transmitted frames; wraps
- frames_dropped  out  CNT_W  count of discarded frames; wraps

Behaviour:
- Reset values: all outputs 0, state IDLE, skid buffer empty, remaining-word counter 0.
- Reset asserted mid-frame: returns to IDLE and drives tvalid=0 from the next cycle. No flush; FIFO pointers are reset by the FIFO owner.
- IDLE:
  - When en=1 and sb_empty=0, pulse sb_ren for 1 cycle and go to SB_WAIT.
  - en=0 holds in IDLE.
  - Deasserting en mid-frame does not interrupt the frame in progress.
- SB_WAIT: capture sb_rdata, load rem=len, then branch:
  - len=0: pulse len_err, consume no frame words, go to IDLE.
  - len>MAX_LEN: pulse len_err, go to DROP.
  - drop=1: go to DROP.
  - otherwise: go to STREAM.
- STREAM:
  - frame_ren=1 when frame_empty=0, rem>0, and (buffered words + words in flight) < 2.
  - Each read decrements rem.
  - Returned words enter a 2-entry skid buffer whose head drives the egress_source outputs.
  - tlast=1 on the word that was read when rem was 1.
  - AXI rule: once tvalid=1, tdata and tlast hold until tready=1.
  - Throughput: 1 word/cycle when tready is held at 1 and the FIFO stays non-empty.
  - Latency: sb_ren in cycle 0 gives the first tvalid in cycle 3.
  - frame_empty mid-frame: stall reads, let the skid buffer drain, and drop tvalid when it is empty. No error is raised.
  - The handshake on the tlast word increments frames_sent and returns to IDLE. The next sb_ren comes no earlier than the following cycle.
- DROP:
  - frame_ren=1 whenever frame_empty=0 and rem>0. Nothing is transmitted.
  - When rem reaches 0 and the last read returns: increment frames_dropped, go to IDLE.
  - An oversize-length frame in DROP is also counted in frames_dropped.
- tready never affects DROP and is ignored in IDLE.
- Simultaneous buffer push and pop in the same cycle is legal, and occupancy is unchanged.
- frame_rdata[19:16] is ignored.

Decomposition:
- Add to packet_filter.svh:
  - MAX_FRAME_HWORDS=759.
  - Sideband field constants: SB_DROP_BIT=19, SB_LEN_LSB=0, SB_LEN_W=11.
  - A sideband_t packed struct {drop, rsvd[7:0], len[10:0]}.
  - The existing axis_source_t/axis_sink_t.
- Sub-module axis_skid_buf: 2-entry 17-bit (data+last) buffer.
  - Inputs: push, data, last.
  - Outputs: count[1:0], AXI source side.
  - Input: tready.

Test Plan:
- Single legal frame: sideband {drop=0,len=4}, words 0x1111..0x4444, tready=1 -> sb_ren cycle 0; tvalid cycles 3-6; tlast only with 0x4444; frames_sent=1.
- Backpressure: len=3 frame, tready toggling 1,0,0,1,0,1,1 -> exactly 3 handshakes; tdata/tlast stable while tready=0; no word lost or duplicated; frame_ren never outruns the 2-entry buffer.
- Drop: {drop=1,len=5} followed by a legal len=2 frame -> 5 frame_ren, no tvalid; frames_dropped=1; then 2 words of the second frame transmitted with tlast on the 2nd.
- Length errors: len=0 -> len_err pulse, 0 frame reads, next descriptor popped. len=800 -> len_err pulse, 800 words discarded, frames_dropped=1.
- Underflow and enable: frame_empty=1 for 4 cycles mid-frame, with en dropped mid-frame -> tvalid goes low, frame resumes and completes with correct tlast; no new sb_ren until en=1.
- Mid-frame reset: reset asserted after 2 of 6 words -> next cycle tvalid=0, counters 0, state IDLE; the next descriptor after release is processed normally.
